// File: rtl/demux_router_pkg.sv
// demux_router_pkg -- shared types and constants for the demux_router slice.
//   ch_state_t : per-channel holding-register state (EMPTY / FULL)
//   CNT_W      : width of each channel's delivered-word counter
//   sat_inc    : saturating increment used by the optional counter
package demux_router_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  localparam int CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/demux_channel.sv
// demux_channel -- one output channel of demux_router: a one-entry holding
// register with an EMPTY/FULL state machine and an optional delivered-word
// counter (built only when DEMUX_ROUTER_COUNT_EN is defined).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : the router accepted a word for this channel this cycle
//   load_data       : word to capture on load
//   out_ready       : sink ready
//   out_valid       : register holds a word (state == FULL)
//   out_data        : held word; keeps its last value while EMPTY
//   out_cnt         : delivered-word count (constant 0 without the macro)
// The router only asserts load while this channel is EMPTY or draining, so a
// load never overwrites an undelivered word.
module demux_channel
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  ch_state_t        state_r;
  logic [WIDTH-1:0] data_r;

  // Holding-register state machine and data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (load) state_r <= FULL;
          else      state_r <= EMPTY;
        end
        FULL: begin
          // A load in the same cycle as a drain keeps the channel FULL.
          if (load)           state_r <= FULL;
          else if (out_ready) state_r <= EMPTY;
          else                state_r <= FULL;
        end
        default: state_r <= EMPTY;
      endcase
      if (load) data_r <= load_data;
      else      data_r <= data_r;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Count completed sink handshakes, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign out_cnt = cnt_r;
`else
  assign out_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/demux_router.sv
// demux_router -- routes a valid/ready source stream to one of NCH = 2**SEL_W
// output channels chosen by in_sel. Each channel buffers one word, so a
// stalled sink only blocks words addressed to it.
// Optional feature macro: DEMUX_ROUTER_COUNT_EN (per-channel delivered-word
// counters on out_cnt; without it out_cnt is constant 0).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : source word valid
//   in_ready   : router accepts a word this cycle (does not look at in_valid)
//   in_data    : source word
//   in_sel     : destination channel index
//   out_valid  : per-channel valid, bit i = channel i
//   out_ready  : per-channel sink ready
//   out_data   : channel i at [i*WIDTH +: WIDTH]
//   out_cnt    : channel i count at [i*8 +: 8]
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  localparam int NCH  = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH*CNT_W-1:0] out_cnt
);

  logic           accept_s;
  logic [NCH-1:0] load_s;

  // The addressed channel can take a word if it is empty or draining now.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept_s = in_valid & in_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load_s[i] = accept_s & (in_sel == SEL_W'(i));

    demux_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH]),
      .out_cnt   (out_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

  localparam int WIDTH = 16;
  localparam int SEL_W = 2;
  localparam int NCH   = 4;
`ifdef DEMUX_ROUTER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH*8-1:0]     out_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel occupancy, held word, delivered count.
  bit          m_full [NCH];
  logic [15:0] m_data [NCH];
  int          m_cnt  [NCH];

  demux_router #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit hs;
      bit acc;
      if (rst) begin
        m_full[c] = 1'b0;
        m_data[c] = 16'h0000;
        m_cnt[c]  = 0;
      end else begin
        hs  = m_full[c] && out_ready[c];
        acc = in_valid && (int'(in_sel) == c) && (!m_full[c] || out_ready[c]);
        if (hs && CNT_EN && m_cnt[c] < 255) m_cnt[c]++;
        if (acc) begin
          m_full[c] = 1'b1;
          m_data[c] = in_data;
        end else if (hs) begin
          m_full[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH-1:0] exp_valid();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_full[c];
    return v;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] exp_data();
    logic [NCH*WIDTH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*WIDTH +: WIDTH] = m_data[c];
    return v;
  endfunction

  function automatic logic [NCH*8-1:0] exp_cnt();
    logic [NCH*8-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'(m_cnt[c]);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_sel = 2'd0; in_data = 16'h0000;
    do_reset();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    checks++;
    if (out_data !== 64'h0 || out_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h/%h want 0/0", out_data, out_cnt);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hBEEF; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) begin
      errors++; $display("FAIL basic_valid got %b want 0100", out_valid);
    end
    checks++;
    if (out_data !== 64'h0000_BEEF_0000_0000) begin
      errors++; $display("FAIL basic_data got %h want 0000beef00000000", out_data);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h0001; out_ready = 4'b0000;
    tick();
    in_data = 16'h0002;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready got %b want 0", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'h0001) begin
        errors++; $display("FAIL stall_hold got %b/%h want 1/0001", out_valid[1], out_data[31:16]);
      end
    end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'h0002) begin
      errors++; $display("FAIL stall_replace got %b/%h want 1/0002", out_valid[1], out_data[31:16]);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid[1] !== 1'b0 || out_data[31:16] !== 16'h0002) begin
      errors++; $display("FAIL empty_retain got %b/%h want 0/0002", out_valid[1], out_data[31:16]);
    end
  endtask

  task automatic test_drain_accept();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h1111; out_ready = 4'b0000;
    tick();
    out_ready = 4'b0001; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'h1234) begin
      errors++; $display("FAIL drain_accept got %b/%h want 1/1234", out_valid[0], out_data[15:0]);
    end
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL drain_after got %b want 0", out_valid[0]);
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    logic [15:0] w;
    do_reset();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 16'h3333; out_ready = 4'b0000;
    tick();
    out_ready = 4'b0001; in_sel = 2'd0;
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      in_data = w;
      #1;
      if (in_ready === 1'b1) accepted++;
      tick();
      checks++;
      if (out_valid !== 4'b1001 || out_data[15:0] !== w || out_data[63:48] !== 16'h3333) begin
        errors++; $display("FAIL b2b_word got %b/%h want 1001/%h", out_valid, out_data, w);
      end
    end
    checks++;
    if (accepted !== 8) begin
      errors++; $display("FAIL b2b_throughput got %0d want 8", accepted);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 16'hAAAA; tick();
    in_sel = 2'd2; in_data = 16'h5555; tick();
    checks++;
    if (out_valid !== 4'b0101) begin
      errors++; $display("FAIL rstmid_setup got %b want 0101", out_valid);
    end
    rst = 1'b1; in_sel = 2'd1; in_data = 16'h7777; out_ready = 4'b1111;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0 || out_cnt !== 32'h0) begin
      errors++; $display("FAIL rstmid_clear got %b/%h/%h want 0/0/0", out_valid, out_data, out_cnt);
    end
    out_ready = 4'b0000; in_sel = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_count();
    int hs;
    int want;
    do_reset();
    in_valid = 1'b1; in_sel = 2'd1; out_ready = 4'b0010;
    hs = 0;
    for (int k = 0; k < 301; k++) begin
      in_data = 16'(k);
      #1;
      if (out_valid[1] === 1'b1) hs++;
      tick();
    end
    in_valid = 1'b0;
    want = CNT_EN ? ((hs > 255) ? 255 : hs) : 0;
    checks++;
    if (out_cnt[15:8] !== 8'(want) || hs !== 300) begin
      errors++; $display("FAIL count_sat got %h (hs %0d) want %h (hs 300)", out_cnt[15:8], hs, 8'(want));
    end
    checks++;
    if (out_cnt !== exp_cnt()) begin
      errors++; $display("FAIL count_model got %h want %h", out_cnt, exp_cnt());
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 16'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_rdy = !m_full[in_sel] || out_ready[in_sel];
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b want %b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid !== exp_valid() || out_data !== exp_data() || out_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL rand_out cyc %0d got %b/%h/%h want %b/%h/%h", k,
                 out_valid, out_data, out_cnt, exp_valid(), exp_data(), exp_cnt());
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 16'h0000; out_ready = 4'b0000;
    for (int c = 0; c < NCH; c++) begin
      m_full[c] = 1'b0; m_data[c] = 16'h0000; m_cnt[c] = 0;
    end
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_drain_accept();
    test_back_to_back();
    test_reset_mid();
    test_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
